// File: rtl/axi_wr_frontend_if.sv
// AXI write-side bundle (AW, W, B) plus the beat-request channel to the scheduler.
// slave modport: the write front end; master modport: interconnect and scheduler side.
// Handshakes are plain valid/ready on every channel.
interface axi_wr_frontend_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_LEN   = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ADDR_LEN-1:0]     awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_strb;
  logic [ID_WIDTH-1:0]     req_id;
  logic                    req_last;

  modport slave (
    input  awvalid, awid, awaddr, awlen, awsize, awburst,
    input  wvalid, wid, wdata, wstrb, wlast,
    input  bready, req_ready,
    output awready, wready, bvalid, bid, bresp,
    output req_valid, req_addr, req_data, req_strb, req_id, req_last
  );

  modport master (
    output awvalid, awid, awaddr, awlen, awsize, awburst,
    output wvalid, wid, wdata, wstrb, wlast,
    output bready, req_ready,
    input  awready, wready, bvalid, bid, bresp,
    input  req_valid, req_addr, req_data, req_strb, req_id, req_last
  );
endinterface

// File: rtl/axi_wr_frontend.sv
// AXI write front end: one burst at a time, per-beat FIXED/INCR/WRAP byte address, one-entry beat buffer.
// Latency: a beat appears on req_* the cycle after its W handshake; B follows the drain of the last beat.
// Backpressure: wready = buffer free (full rate when req_ready=1); AW/W held off outside IDLE/DATA.
// Optional: define AXI_WR_ALIGN_CHECK_EN to flag and align misaligned or oversized AW requests.
module axi_wr_frontend #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_LEN   = 4
) (
  input logic clk,
  input logic rst_n,
  axi_wr_frontend_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q;
  logic                  awready_q, bvalid_q, err_q, req_valid_q, req_last_q;
  logic [ID_WIDTH-1:0]   id_q, bid_q, req_id_q;
  logic [1:0]            bresp_q, mode_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d, req_addr_q;
  logic [ADDR_LEN-1:0]   len_q, beat_cnt_q;
  logic [2:0]            size_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic [STRB_W-1:0]     req_strb_q;

  logic                  aw_fire, w_fire, wready_c, beat_last, beat_err, aw_wrap_ok, aw_err;
  logic [1:0]            aw_mode;
  logic [ADDR_WIDTH-1:0] aw_addr, step, region, incr_addr;

  assign wready_c  = (state_q == DATA) && (!req_valid_q || bus.req_ready);
  assign aw_fire   = bus.awvalid && awready_q;
  assign w_fire    = bus.wvalid && wready_c;
  assign beat_last = (beat_cnt_q == len_q);
  assign beat_err  = (bus.wid != id_q) || (bus.wlast != beat_last);

  assign bus.awready   = awready_q;
  assign bus.wready    = wready_c;
  assign bus.bvalid    = bvalid_q;
  assign bus.bid       = bid_q;
  assign bus.bresp     = bresp_q;
  assign bus.req_valid = req_valid_q;
  assign bus.req_addr  = req_addr_q;
  assign bus.req_data  = req_data_q;
  assign bus.req_strb  = req_strb_q;
  assign bus.req_id    = req_id_q;
  assign bus.req_last  = req_last_q;

`ifdef AXI_WR_ALIGN_CHECK_EN
  logic [ADDR_WIDTH-1:0] aw_step;
  assign aw_step = ADDR_WIDTH'(1) << bus.awsize;
`endif

  // Decode the AW request: effective burst mode, error flag and start address.
  always_comb begin
    aw_wrap_ok = (bus.awlen == ADDR_LEN'(1)) || (bus.awlen == ADDR_LEN'(3)) ||
                 (bus.awlen == ADDR_LEN'(7)) || (bus.awlen == ADDR_LEN'(15));
    aw_mode = BURST_INCR;
    aw_err  = 1'b0;
    aw_addr = bus.awaddr;
    if (bus.awburst == BURST_FIXED) begin
      aw_mode = BURST_FIXED;
    end else if (bus.awburst == BURST_WRAP) begin
      if (aw_wrap_ok) aw_mode = BURST_WRAP;
      else            aw_err  = 1'b1;
    end else if (bus.awburst == BURST_RSVD) begin
      aw_err = 1'b1;
    end
`ifdef AXI_WR_ALIGN_CHECK_EN
    if ((|(bus.awaddr & (aw_step - ADDR_WIDTH'(1)))) || (aw_step > ADDR_WIDTH'(STRB_W))) begin
      aw_err  = 1'b1;
      aw_addr = bus.awaddr & ~(aw_step - ADDR_WIDTH'(1));
    end
`endif
  end

  // Address of the next beat; WRAP stays inside the (len+1)*step aligned region.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_q;
    region    = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
    incr_addr = cur_addr_q + step;
    case (mode_q)
      BURST_FIXED: cur_addr_d = cur_addr_q;
      BURST_WRAP:  cur_addr_d = (cur_addr_q & ~(region - ADDR_WIDTH'(1))) |
                                (incr_addr & (region - ADDR_WIDTH'(1)));
      default:     cur_addr_d = incr_addr;
    endcase
  end

  // Burst FSM with registered AW/B outputs and the one-entry request buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= 2'b00;
      err_q       <= 1'b0;
      id_q        <= '0;
      mode_q      <= BURST_INCR;
      cur_addr_q  <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      size_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_strb_q  <= '0;
      req_id_q    <= '0;
      req_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          awready_q <= 1'b1;
          if (aw_fire) begin
            awready_q  <= 1'b0;
            id_q       <= bus.awid;
            cur_addr_q <= aw_addr;
            len_q      <= bus.awlen;
            size_q     <= bus.awsize;
            mode_q     <= aw_mode;
            beat_cnt_q <= '0;
            err_q      <= aw_err;
            state_q    <= DATA;
          end
        end
        DATA: begin
          if (w_fire) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= cur_addr_q;
            req_data_q  <= bus.wdata;
            req_strb_q  <= bus.wstrb;
            req_id_q    <= id_q;
            req_last_q  <= beat_last;
            cur_addr_q  <= cur_addr_d;
            beat_cnt_q  <= beat_cnt_q + 1'b1;
            if (beat_err) err_q <= 1'b1;
            if (beat_last) state_q <= RESP;
          end else if (bus.req_ready) begin
            req_valid_q <= 1'b0;
          end
        end
        RESP: begin
          if (bus.req_ready) req_valid_q <= 1'b0;
          if (!bvalid_q && (!req_valid_q || bus.req_ready)) begin
            bvalid_q <= 1'b1;
            bid_q    <= id_q;
            bresp_q  <= err_q ? 2'b10 : 2'b00;
          end else if (bvalid_q && bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_wr_frontend.sv
// Directed bench for axi_wr_frontend: scoreboard of expected beats, B checks, stall and reset checks.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Scheduler ready is either held high or cycled 1,0,0 to exercise the buffer.
module tb_axi_wr_frontend;
  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic [3:0]   id;
    logic         last;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    total = 0;
  int    bad = 0;
  int    hs_cnt = 0;
  int    rdy_mode = 0;
  int    cyc = 0;
  beat_t exp_q[$];
  logic [31:0] ea [16];
  logic  stall_seen = 1'b0;
  beat_t hold;

  axi_wr_frontend_if #(.ADDR_WIDTH(32), .ID_WIDTH(4), .DATA_WIDTH(128), .ADDR_LEN(4)) bus();

  axi_wr_frontend #(.ADDR_WIDTH(32), .ID_WIDTH(4), .DATA_WIDTH(128), .ADDR_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scheduler ready: constant 1 or the 1,0,0 pattern.
  initial begin
    bus.req_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.req_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  // Output monitor: scoreboard pop on each req handshake, stall stability, wready and bvalid ordering.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        total++;
        assert (bus.req_valid === 1'b1 && bus.req_addr === hold.addr && bus.req_data === hold.data &&
                bus.req_strb === hold.strb && bus.req_id === hold.id && bus.req_last === hold.last)
        else begin bad++; $error("FAIL stall_stable got addr=%h valid=%b want addr=%h valid=1", bus.req_addr, bus.req_valid, hold.addr); end
      end
      if (bus.req_valid && !bus.req_ready) begin
        total++;
        assert (bus.wready === 1'b0)
        else begin bad++; $error("FAIL wready_full got %b want 0", bus.wready); end
      end
      stall_seen = bus.req_valid && !bus.req_ready;
      hold = '{addr: bus.req_addr, data: bus.req_data, strb: bus.req_strb, id: bus.req_id, last: bus.req_last};
      if (bus.req_valid && bus.req_ready) begin
        total++;
        assert (exp_q.size() > 0)
        else begin bad++; $error("FAIL extra_beat got addr=%h want no beat", bus.req_addr); end
        if (exp_q.size() > 0) begin
          beat_t e;
          e = exp_q.pop_front();
          total++;
          assert (bus.req_addr === e.addr)
          else begin bad++; $error("FAIL req_addr got %h want %h", bus.req_addr, e.addr); end
          total++;
          assert (bus.req_last === e.last && bus.req_id === e.id)
          else begin bad++; $error("FAIL req_last_id got last=%b id=%h want last=%b id=%h", bus.req_last, bus.req_id, e.last, e.id); end
          total++;
          assert (bus.req_data === e.data && bus.req_strb === e.strb)
          else begin bad++; $error("FAIL req_data got %h/%h want %h/%h", bus.req_data, bus.req_strb, e.data, e.strb); end
        end
        hs_cnt++;
      end
      if (bus.bvalid) begin
        total++;
        assert (exp_q.size() == 0)
        else begin bad++; $error("FAIL b_early got pending=%0d want 0", exp_q.size()); end
      end
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
    bus.awlen = 4'(len); bus.awsize = size; bus.awburst = burst;
    @(negedge clk);
    while (!bus.awready && n < 200) begin @(negedge clk); n++; end
    total++;
    assert (bus.awready === 1'b1)
    else begin bad++; $error("FAIL aw_timeout got awready=%b want 1", bus.awready); end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [127:0] d, input logic [15:0] s, input logic [3:0] id, input logic last);
    int n = 0;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; bus.wid = id; bus.wlast = last;
    @(negedge clk);
    while (!bus.wready && n < 200) begin @(negedge clk); n++; end
    total++;
    assert (bus.wready === 1'b1)
    else begin bad++; $error("FAIL w_timeout got wready=%b want 1", bus.wready); end
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask

  task automatic expect_b(input logic [3:0] id, input logic [1:0] resp, input int nbeats);
    int n = 0;
    @(negedge clk);
    while (!bus.bvalid && n < 200) begin @(negedge clk); n++; end
    total++;
    assert (bus.bvalid === 1'b1)
    else begin bad++; $error("FAIL b_timeout got bvalid=%b want 1", bus.bvalid); end
    total++;
    assert (bus.bid === id)
    else begin bad++; $error("FAIL bid got %h want %h", bus.bid, id); end
    total++;
    assert (bus.bresp === resp)
    else begin bad++; $error("FAIL bresp got %b want %b", bus.bresp, resp); end
    total++;
    assert (hs_cnt === nbeats)
    else begin bad++; $error("FAIL beat_count got %0d want %0d", hs_cnt, nbeats); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    assert (bus.bvalid === 1'b0)
    else begin bad++; $error("FAIL b_drop got bvalid=%b want 0", bus.bvalid); end
    @(posedge clk); #1;
  endtask

  // One full burst; ea[] holds the expected beat addresses; bad_wid/early_last pick faulty beats (-1 none).
  task automatic do_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input int bad_wid, input int early_last, input logic [1:0] resp);
    hs_cnt = 0;
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i <= len; i++) begin
      beat_t e;
      e.addr = ea[i];
      e.data = {$urandom, $urandom, $urandom, $urandom};
      e.strb = 16'($urandom);
      e.id   = id;
      e.last = (i == len);
      exp_q.push_back(e);
      send_w(e.data, e.strb, (i == bad_wid) ? (id ^ 4'hF) : id, (i == len) || (i == early_last));
    end
    expect_b(id, resp, len + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    total++;
    assert (bus.awready === 1'b0 && bus.wready === 1'b0 && bus.bvalid === 1'b0)
    else begin bad++; $error("FAIL %s_hs got aw=%b w=%b b=%b want 0/0/0", tag, bus.awready, bus.wready, bus.bvalid); end
    total++;
    assert (bus.bid === 4'h0 && bus.bresp === 2'b00)
    else begin bad++; $error("FAIL %s_b got bid=%h bresp=%b want 0/00", tag, bus.bid, bus.bresp); end
    total++;
    assert (bus.req_valid === 1'b0 && bus.req_addr === 32'h0 && bus.req_data === 128'h0 &&
            bus.req_strb === 16'h0 && bus.req_id === 4'h0 && bus.req_last === 1'b0)
    else begin bad++; $error("FAIL %s_req got valid=%b addr=%h want 0/0", tag, bus.req_valid, bus.req_addr); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 1'b0; bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // INCR, 4 x 16 bytes
    ea[0] = 32'h1000; ea[1] = 32'h1010; ea[2] = 32'h1020; ea[3] = 32'h1030;
    do_burst(4'd5, 32'h1000, 3, 3'd4, 2'b01, -1, -1, 2'b00);

    // WRAP, 4 x 8 bytes inside a 32-byte region
    ea[0] = 32'h1038; ea[1] = 32'h1020; ea[2] = 32'h1028; ea[3] = 32'h1030;
    do_burst(4'd6, 32'h1038, 3, 3'd3, 2'b10, -1, -1, 2'b00);

    // FIXED keeps the address
    ea[0] = 32'h4000; ea[1] = 32'h4000; ea[2] = 32'h4000;
    do_burst(4'd4, 32'h4000, 2, 3'd2, 2'b00, -1, -1, 2'b00);

    // Reserved burst type behaves as INCR and reports SLVERR
    ea[0] = 32'h5000; ea[1] = 32'h5004;
    do_burst(4'd8, 32'h5000, 1, 3'd2, 2'b11, -1, -1, 2'b10);

    // WRAP with a 3-beat length behaves as INCR and reports SLVERR
    ea[0] = 32'h6008; ea[1] = 32'h600C; ea[2] = 32'h6010;
    do_burst(4'd9, 32'h6008, 2, 3'd2, 2'b10, -1, -1, 2'b10);

    // INCR at the top of the address space rolls over to zero
    ea[0] = 32'hFFFF_FFF0; ea[1] = 32'h0000_0000;
    do_burst(4'd10, 32'hFFFF_FFF0, 1, 3'd4, 2'b01, -1, -1, 2'b00);

    // Back-pressure: 8 beats while the scheduler ready cycles 1,0,0
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) ea[i] = 32'h8000 + 32'(i * 16);
    do_burst(4'd1, 32'h8000, 7, 3'd4, 2'b01, -1, -1, 2'b00);
    rdy_mode = 0;

    // Protocol errors: early wlast on beat 2, wrong wid on beat 3; still 4 beats
    ea[0] = 32'h3000; ea[1] = 32'h3010; ea[2] = 32'h3020; ea[3] = 32'h3030;
    do_burst(4'd2, 32'h3000, 3, 3'd4, 2'b01, 2, 1, 2'b10);

    // Reset after beat 2 of 4: burst is discarded with no response
    hs_cnt = 0;
    send_aw(4'd7, 32'h2100, 3, 3'd4, 2'b01);
    for (int i = 0; i < 2; i++) begin
      beat_t e;
      e.addr = 32'h2100 + 32'(i * 16);
      e.data = {$urandom, $urandom, $urandom, $urandom};
      e.strb = 16'($urandom);
      e.id   = 4'd7;
      e.last = 1'b0;
      exp_q.push_back(e);
      send_w(e.data, e.strb, 4'd7, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    ea[0] = 32'h2000;
    do_burst(4'd3, 32'h2000, 0, 3'd4, 2'b01, -1, -1, 2'b00);

    // Misaligned start address
`ifdef AXI_WR_ALIGN_CHECK_EN
    ea[0] = 32'h1000; ea[1] = 32'h1010;
    do_burst(4'd11, 32'h1004, 1, 3'd4, 2'b01, -1, -1, 2'b10);
`else
    ea[0] = 32'h1004; ea[1] = 32'h1014;
    do_burst(4'd11, 32'h1004, 1, 3'd4, 2'b01, -1, -1, 2'b00);
`endif

    repeat (3) @(posedge clk);
    #1;
    total++;
    assert (exp_q.size() == 0)
    else begin bad++; $error("FAIL leftover got %0d beats want 0", exp_q.size()); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
